byte_unstripping_n: RTL
=======================

Name: byte_unstripping_n

Overview:
Parametrised successor of the PHY receive-side byte unstriper. Takes one word per lane from LANES parallel lanes (all lanes updated together at the lane rate). Serialises the lanes in ascending lane order onto a single DATA_W output at the fast clock, one lane per cycle. Adds an optional skip-invalid compaction mode, back-to-back capture and sticky overrun detection, and sits between the per-lane deserialisers and the data demux.

Parameters:
LANES, 2, number of input lanes; legal values are 2 or greater, and powers of two are not required.
DATA_W, 8, width of each lane word and of the output.
SKIP_INVALID, 0, 0 = emit every lane slot (invalid lanes emit valid=0, data=0); 1 = emit only lanes whose valid bit is set, with no idle slots.

Ports:
clk_nf  input  1  fast clock, LANES x lane rate; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
data_par  input  LANES*DATA_W  packed lane words; lane i = data_par[i*DATA_W +: DATA_W].
valid_par  input  LANES  per-lane valid; bit i qualifies lane i.
par_stb  input  1  one-cycle pulse: data_par/valid_par hold a new lane set this cycle.
overrun_clr  input  1  synchronous clear of overrun.
data_unstripped  output  DATA_W  serialised lane word.
valid_unstripped  output  1  qualifies data_unstripped.
busy  output  1  high while lanes remain to be emitted after the current cycle.
overrun  output  1  sticky: a strobe arrived while a set was still being emitted.

Behaviour:
- Reset (async, while high): data_unstripped=0, valid_unstripped=0, busy=0, overrun=0, FSM=IDLE, lane index=0, hold registers=0.
- Internal state:
  - hold_data[LANES], hold_valid[LANES] (the pending mask);
  - lane index of width max(1,$clog2(LANES));
  - FSM with states IDLE and EMIT.
- Accept condition: par_stb=1 AND |valid_par=1, AND (FSM=IDLE OR the current cycle is the last emission of the set). A strobe with valid_par all zero is ignored: no capture, no overrun, no state change.
- On accept (edge t), latency is 1 cycle:
  - The first lane to emit drives the outputs immediately after edge t.
  - SKIP_INVALID=0: the first lane is lane 0.
  - SKIP_INVALID=1: the first lane is the lowest-numbered set valid bit.
  - The remaining lanes are stored in the hold registers. The FSM goes to EMIT if any lanes remain, otherwise to IDLE.
- EMIT, one lane per edge, ascending order:
  - SKIP_INVALID=0: lanes 0..LANES-1 in turn, LANES output cycles total. An invalid lane emits valid_unstripped=0, data_unstripped=0.
  - SKIP_INVALID=1: next set bit of the pending mask; popcount(valid_par) output cycles total; valid_unstripped=1 on every one.
  - After the last lane is emitted: go to IDLE unless an accept occurs in the same cycle, in which case the new set's first lane follows with no gap.
- IDLE (not accepting): data_unstripped=0, valid_unstripped=0.
- busy=1 exactly on output cycles that are followed by at least one more lane of the same set.
- Overrun: par_stb=1 with |valid_par=1 while busy=1 (not on the last emission cycle).
  - The strobe is dropped; the current set completes unchanged.
  - overrun is set to 1 on the next edge.
- overrun_clr=1 clears overrun on the next edge. If it coincides with a new overrun event, set wins.
- Input data of invalid lanes is never propagated in either mode.
- Reset asserted mid-set aborts emission immediately (async). After reset deasserts, the block waits in IDLE for the next strobe.

Test Plan:
- Reset behaviour: assert reset mid-EMIT with LANES=4 -> outputs, busy and overrun go 0 without a clock edge. Release reset, strobe {0x44,0x33,0x22,0x11} all valid -> output 0x11,0x22,0x33,0x44 on 4 consecutive cycles, valid=1.
- Default mode, LANES=2: par_stb every 2 cycles with (lane0,lane1)=(0xA0,0xA1),(0xB0,0xB1) -> continuous stream A0,A1,B0,B1, valid=1 throughout, busy toggling 1,0,1,0, overrun=0.
- SKIP_INVALID=0, LANES=4, valid_par=4'b1010, data lanes 0..3 = 0x10,0x20,0x30,0x40 -> outputs (0,v0),(0x20,v1),(0,v0),(0x40,v1) then IDLE.
- SKIP_INVALID=1, same stimulus -> exactly 2 output cycles, 0x20 then 0x40, both valid=1. valid_par=4'b0000 with par_stb -> no output, no overrun.
- Overrun: LANES=4, second strobe 2 cycles after the first -> first set emitted intact, second set dropped, overrun=1 sticky. Pulse overrun_clr -> overrun=0 on the next edge. A strobe on the last emission cycle -> back-to-back, no overrun.
- Boundary, LANES=3, DATA_W=16, default mode: strobe every 3 cycles with 0xBEEF,0xCAFE,0x1234 -> lane index wraps 2->0 cleanly, output BEEF,CAFE,1234 repeating with no gaps.

Source files
------------

// File: rtl/byte_unstripping_n_if.sv
// byte_unstripping_n_if: lane-parallel input bus and serialised output bus
interface byte_unstripping_n_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 8
);
    logic [LANES*DATA_W-1:0] data_par;
    logic [LANES-1:0]        valid_par;
    logic                    par_stb;
    logic                    overrun_clr;
    logic [DATA_W-1:0]       data_unstripped;
    logic                    valid_unstripped;
    logic                    busy;
    logic                    overrun;

    modport master (
        output data_par, valid_par, par_stb, overrun_clr,
        input  data_unstripped, valid_unstripped, busy, overrun
    );

    modport slave (
        input  data_par, valid_par, par_stb, overrun_clr,
        output data_unstripped, valid_unstripped, busy, overrun
    );
endinterface

// File: rtl/byte_unstripping_n.sv
// byte_unstripping_n: serialises LANES parallel lane words onto one output, one lane per fast clock
module byte_unstripping_n #(
    parameter int LANES        = 2,
    parameter int DATA_W       = 8,
    parameter bit SKIP_INVALID = 1'b0
) (
    input  logic                 clk_nf,
    input  logic                 reset,
    byte_unstripping_n_if.slave  bus
);
    localparam int IW = ($clog2(LANES) > 1) ? $clog2(LANES) : 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     idx, idx_n, first;
    logic [LANES-1:0]  pend, pend_n, hold_valid, hold_valid_n, in_mask, rem;
    logic [DATA_W-1:0] hold_data   [LANES];
    logic [DATA_W-1:0] hold_data_n [LANES];
    logic [DATA_W-1:0] data_q, data_n;
    logic              valid_q, valid_n, overrun_q, overrun_n, strobe;

    function automatic logic [IW-1:0] lowest(input logic [LANES-1:0] m);
        lowest = '0;
        for (int i = LANES - 1; i >= 0; i--) if (m[i]) lowest = IW'(i);
    endfunction

    // Next lane selection: pend holds the lanes still owed (idx is the next one), EMIT means more remain
    always_comb begin
        strobe       = bus.par_stb && |bus.valid_par;
        in_mask      = SKIP_INVALID ? bus.valid_par : '1;
        first        = lowest(in_mask);
        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        data_n       = '0;
        valid_n      = 1'b0;
        rem          = '0;
        overrun_n    = (strobe && state == EMIT) ? 1'b1 : bus.overrun_clr ? 1'b0 : overrun_q;
        if (strobe && state == IDLE) begin
            for (int i = 0; i < LANES; i++)
                hold_data_n[i] = bus.valid_par[i] ? bus.data_par[i*DATA_W +: DATA_W] : '0;
            hold_valid_n = bus.valid_par;
            data_n       = hold_data_n[first];
            valid_n      = bus.valid_par[first];
            rem          = in_mask & ~(LANES'(1) << first);
        end else if (state == EMIT) begin
            data_n  = hold_data[idx];
            valid_n = hold_valid[idx];
            rem     = pend & ~(LANES'(1) << idx);
        end
        pend_n  = rem;
        idx_n   = lowest(rem);
        state_n = |rem ? EMIT : IDLE;
    end

    // State, hold registers and registered outputs; reset aborts any set in flight
    always_ff @(posedge clk_nf or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            pend       <= '0;
            hold_valid <= '0;
            hold_data  <= '{default: '0};
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            pend       <= pend_n;
            hold_valid <= hold_valid_n;
            hold_data  <= hold_data_n;
            data_q     <= data_n;
            valid_q    <= valid_n;
            overrun_q  <= overrun_n;
        end
    end

    assign bus.data_unstripped  = data_q;
    assign bus.valid_unstripped = valid_q;
    assign bus.busy             = (state == EMIT);
    assign bus.overrun          = overrun_q;
endmodule
